// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  // Sequencer states. Encoding 2'd3 is unused and decodes as CTRL_RUN.
  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_MEM_WAIT = 2'd1,
    CTRL_MDU_WAIT = 2'd2
  } ctrl_state_e;

  localparam int unsigned PERF_W_DEF = 32;

  // Every hold/bubble control driven by the sequencer, bundled so the
  // priority mux can move them around as one value.
  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_me;
    logic flush_id;
    logic flush_ex;
    logic flush_me;
    logic flush_wb;
    logic mdu_go;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_NONE = '0;

  // While reset is held every pipeline register loads a NOP and nothing holds.
  function automatic ctrl_out_t ctrl_reset();
    ctrl_out_t c;
    c          = CTRL_NONE;
    c.flush_id = 1'b1;
    c.flush_ex = 1'b1;
    c.flush_me = 1'b1;
    c.flush_wb = 1'b1;
    return c;
  endfunction

  // Data-bus wait: freeze IF..ME, let a bubble drain into WB.
  function automatic ctrl_out_t ctrl_memwait();
    ctrl_out_t c;
    c          = CTRL_NONE;
    c.stall_if = 1'b1;
    c.stall_id = 1'b1;
    c.stall_ex = 1'b1;
    c.stall_me = 1'b1;
    c.flush_wb = 1'b1;
    return c;
  endfunction

  // MDU occupancy: freeze IF..EX, feed bubbles into ME. go marks the start cycle.
  function automatic ctrl_out_t ctrl_mdu_hold(input logic go);
    ctrl_out_t c;
    c          = CTRL_NONE;
    c.stall_if = 1'b1;
    c.stall_id = 1'b1;
    c.stall_ex = 1'b1;
    c.flush_me = 1'b1;
    c.mdu_go   = go;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detector: the EX instruction is a load whose destination
// is read by the ID instruction, so forwarding cannot cover it this cycle.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       id_rs1_ren_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic       id_rs2_ren_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       ex_rd_wena_i,
  input  logic [4:0] ex_rd_waddr_i,
  input  logic       ex_mem_ren_i,
  output logic       load_use_o
);

  logic ex_is_load_wr;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  always_comb begin
    ex_is_load_wr = ex_rd_wena_i & ex_mem_ren_i & (ex_rd_waddr_i != 5'd0);
    rs1_hit       = id_rs1_ren_i & (id_rs1_addr_i == ex_rd_waddr_i);
    rs2_hit       = id_rs2_ren_i & (id_rs2_addr_i == ex_rd_waddr_i);
    load_use_o    = ex_is_load_wr & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage core.
// Handshake: an ME data access is outstanding while me_mem_req=1 and
// me_mem_ack=0; it completes in the cycle me_mem_ack=1. The MDU starts on
// a one-cycle mdu_go pulse and reports completion with a one-cycle mdu_done.
// All controls are combinational from state + inputs; only the state and
// the stall counter are registered.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned PERF_W = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_rs1_ren,
  input  logic [4:0]        id_rs1_addr,
  input  logic              id_rs2_ren,
  input  logic [4:0]        id_rs2_addr,
  input  logic              ex_rd_wena,
  input  logic [4:0]        ex_rd_waddr,
  input  logic              ex_mem_ren,
  input  logic              ex_mdu_op,
  input  logic              ex_redirect,
  input  logic              mdu_done,
  output logic              mdu_go,
  input  logic              me_mem_req,
  input  logic              me_mem_ack,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              stall_me,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              flush_me,
  output logic              flush_wb,
  output logic [1:0]        ctrl_state,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  ctrl_state_e       state_q, state_d;
  logic [PERF_W-1:0] cnt_q, cnt_d;
  ctrl_out_t         run_ctrl;
  ctrl_state_e       run_next;
  ctrl_out_t         ctrl;
  logic              load_use;
  logic              memwait;

  load_use_detect u_load_use (
    .id_rs1_ren_i  (id_rs1_ren),
    .id_rs1_addr_i (id_rs1_addr),
    .id_rs2_ren_i  (id_rs2_ren),
    .id_rs2_addr_i (id_rs2_addr),
    .ex_rd_wena_i  (ex_rd_wena),
    .ex_rd_waddr_i (ex_rd_waddr),
    .ex_mem_ren_i  (ex_mem_ren),
    .load_use_o    (load_use)
  );

  // Outstanding data access that does not complete this cycle.
  always_comb begin
    memwait = me_mem_req & ~me_mem_ack;
  end

  // Lower part of the RUN priority chain (MDU start, redirect, load-use),
  // shared by RUN and by the cycle a bus wait is acknowledged.
  always_comb begin
    run_ctrl = CTRL_NONE;
    run_next = CTRL_RUN;
    if (ex_mdu_op) begin
      run_ctrl = ctrl_mdu_hold(1'b1);
      run_next = CTRL_MDU_WAIT;
    end else if (ex_redirect) begin
      // The ID instruction is wrong-path, so a load-use stall would be wasted.
      run_ctrl.flush_id = 1'b1;
      run_ctrl.flush_ex = 1'b1;
    end else if (load_use) begin
      run_ctrl.stall_if = 1'b1;
      run_ctrl.stall_id = 1'b1;
      run_ctrl.flush_ex = 1'b1;
    end
  end

  // Next-state and output decode; reset overrides every control.
  always_comb begin
    ctrl    = CTRL_NONE;
    state_d = CTRL_RUN;
    case (state_q)
      CTRL_MEM_WAIT: begin
        if (!me_mem_ack) begin
          ctrl    = ctrl_memwait();
          state_d = CTRL_MEM_WAIT;
        end else begin
          ctrl    = run_ctrl;
          state_d = run_next;
        end
      end
      CTRL_MDU_WAIT: begin
        // ME only holds bubbles here, so a bus wait cannot arise. On mdu_done
        // everything releases and the result moves into EX/ME.
        if (!mdu_done) begin
          ctrl    = ctrl_mdu_hold(1'b0);
          state_d = CTRL_MDU_WAIT;
        end
      end
      default: begin
        if (memwait) begin
          ctrl    = ctrl_memwait();
          state_d = CTRL_MEM_WAIT;
        end else begin
          ctrl    = run_ctrl;
          state_d = run_next;
        end
      end
    endcase
    if (rst) begin
      ctrl = ctrl_reset();
    end
  end

  // Saturating count of cycles in which IF/ID is held.
  always_comb begin
    cnt_d = cnt_q;
    if (ctrl.stall_id && (cnt_q != {PERF_W{1'b1}})) begin
      cnt_d = cnt_q + PERF_W'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CTRL_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output mapping.
  always_comb begin
    stall_if       = ctrl.stall_if;
    stall_id       = ctrl.stall_id;
    stall_ex       = ctrl.stall_ex;
    stall_me       = ctrl.stall_me;
    flush_id       = ctrl.flush_id;
    flush_ex       = ctrl.flush_ex;
    flush_me       = ctrl.flush_me;
    flush_wb       = ctrl.flush_wb;
    mdu_go         = ctrl.mdu_go;
    ctrl_state     = state_q;
    perf_stall_cnt = cnt_q;
  end

endmodule
